// File: rtl/game_pkg.sv
// Shared definitions for the Arkanoid round sequencer: state codes,
// counter widths and the default frame counts for the timed pauses.
package game_pkg;

    localparam int STATE_W = 3;
    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_MISS    = 3'd3,
        ST_LEVELUP = 3'd4,
        ST_OVER    = 3'd5
    } state_e;

    localparam int DEF_LIVES_INIT     = 3;
    localparam int DEF_LEVELS         = 4;
    localparam int DEF_MISS_FRAMES    = 60;
    localparam int DEF_LEVELUP_FRAMES = 120;
    localparam int DEF_OVER_FRAMES    = 180;
    localparam int DEF_SERVE_FRAMES   = 300;

endpackage

// File: rtl/frame_timer.sv
// Saturating frame counter shared by all timed round phases.
// done is a combinational pulse on the frame_tick that completes 'limit' frames.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             clear,
    input  logic             frame_tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    assign done = frame_tick && (cnt_q == (limit - CNT_W'(1)));

    // Count frame ticks, holding at all-ones rather than wrapping.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (frame_tick && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/round_ctl.sv
// Game-round sequencer: gates the paddle, holds/launches the ball, tracks
// lives and level, and times the pauses between rounds in display frames.
// Optional build macro ROUND_CTL_AUTO_SERVE_EN: SERVE launches the ball on
// its own after SERVE_FRAMES frames without a click.
//
// state   | meaning
// IDLE    | attract screen, waiting for a click to start a game
// SERVE   | ball glued to paddle, waiting for the launch click
// PLAY    | ball in flight
// MISS    | pause after a lost ball
// LEVELUP | pause after a cleared field
// OVER    | game-over screen
module round_ctl
    import game_pkg::*;
#(
    parameter int LIVES_INIT     = DEF_LIVES_INIT,
    parameter int LEVELS         = DEF_LEVELS,
    parameter int MISS_FRAMES    = DEF_MISS_FRAMES,
    parameter int LEVELUP_FRAMES = DEF_LEVELUP_FRAMES,
    parameter int OVER_FRAMES    = DEF_OVER_FRAMES,
    parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               mouse_left,
    input  logic               ball_lost,
    input  logic               bricks_clear,
    output logic               paddle_en,
    output logic               ball_hold,
    output logic               ball_launch,
    output logic               field_reload,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic [STATE_W-1:0] state
);

`ifdef ROUND_CTL_AUTO_SERVE_EN
    localparam int CNT_W = 9;
`else
    localparam int CNT_W = 8;
`endif

    state_e             state_q;
    logic               mouse_left_q;
    logic               paddle_en_q;
    logic               ball_hold_q;
    logic               ball_launch_q;
    logic               field_reload_q;
    logic [LIVES_W-1:0] lives_q;
    logic [LEVEL_W-1:0] level_q;

    logic               click;
    logic               timed;
    logic               tmr_clear;
    logic               tmr_done;
    logic [CNT_W-1:0]   tmr_limit;

    assign click = mouse_left & ~mouse_left_q;

    // Remember the previous button level for rising-edge detection.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            mouse_left_q <= 1'b0;
        end else begin
            mouse_left_q <= mouse_left;
        end
    end

    // Pick the pause length for the current phase. SERVE falls into the
    // default; without auto-serve the counter is held clear there, so the
    // value is never acted on.
    always_comb begin
        tmr_limit = CNT_W'(SERVE_FRAMES);
        case (state_q)
            ST_MISS:    tmr_limit = CNT_W'(MISS_FRAMES);
            ST_LEVELUP: tmr_limit = CNT_W'(LEVELUP_FRAMES);
            ST_OVER:    tmr_limit = CNT_W'(OVER_FRAMES);
            default:    tmr_limit = CNT_W'(SERVE_FRAMES);
        endcase
    end

    // Flag the phases that count frames.
    always_comb begin
        timed = (state_q == ST_MISS) || (state_q == ST_LEVELUP) || (state_q == ST_OVER);
`ifdef ROUND_CTL_AUTO_SERVE_EN
        timed = timed || (state_q == ST_SERVE);
`endif
    end

    // Untimed phases hold the counter at zero, so every timed phase starts
    // from zero; done clears it on the exit edge.
    assign tmr_clear = tmr_done | ~timed;

    frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .pclk       (pclk),
        .reset      (reset),
        .clear      (tmr_clear),
        .frame_tick (frame_tick),
        .limit      (tmr_limit),
        .done       (tmr_done)
    );

    // Round sequencer with registered outputs; pulses default low each cycle.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            paddle_en_q    <= 1'b0;
            ball_hold_q    <= 1'b1;
            ball_launch_q  <= 1'b0;
            field_reload_q <= 1'b0;
            lives_q        <= LIVES_W'(LIVES_INIT);
            level_q        <= '0;
        end else begin
            ball_launch_q  <= 1'b0;
            field_reload_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (click) begin
                        lives_q        <= LIVES_W'(LIVES_INIT);
                        level_q        <= '0;
                        field_reload_q <= 1'b1;
                        paddle_en_q    <= 1'b1;
                        ball_hold_q    <= 1'b1;
                        state_q        <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
`ifdef ROUND_CTL_AUTO_SERVE_EN
                    if (click || tmr_done) begin
`else
                    if (click) begin
`endif
                        ball_launch_q <= 1'b1;
                        ball_hold_q   <= 1'b0;
                        paddle_en_q   <= 1'b1;
                        state_q       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (bricks_clear) begin
                        paddle_en_q <= 1'b0;
                        ball_hold_q <= 1'b1;
                        state_q     <= ST_LEVELUP;
                    end else if (ball_lost) begin
                        paddle_en_q <= 1'b0;
                        ball_hold_q <= 1'b1;
                        if (lives_q > LIVES_W'(1)) begin
                            lives_q <= lives_q - LIVES_W'(1);
                            state_q <= ST_MISS;
                        end else begin
                            lives_q <= '0;
                            state_q <= ST_OVER;
                        end
                    end
                end
                ST_MISS: begin
                    if (tmr_done) begin
                        paddle_en_q <= 1'b1;
                        ball_hold_q <= 1'b1;
                        state_q     <= ST_SERVE;
                    end
                end
                ST_LEVELUP: begin
                    if (tmr_done) begin
                        level_q        <= (level_q == LEVEL_W'(LEVELS - 1)) ? '0 : level_q + LEVEL_W'(1);
                        field_reload_q <= 1'b1;
                        paddle_en_q    <= 1'b1;
                        ball_hold_q    <= 1'b1;
                        state_q        <= ST_SERVE;
                    end
                end
                ST_OVER: begin
                    if (tmr_done) begin
                        paddle_en_q <= 1'b0;
                        ball_hold_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    paddle_en_q <= 1'b0;
                    ball_hold_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign paddle_en    = paddle_en_q;
    assign ball_hold    = ball_hold_q;
    assign ball_launch  = ball_launch_q;
    assign field_reload = field_reload_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign state        = state_q;

endmodule

// File: tb/tb_round_ctl.sv
// Bench for round_ctl: directed walk through a game plus a randomized run,
// all outputs compared every cycle against a phase/countdown model.
module tb_round_ctl;

    localparam int LIVES_INIT     = 3;
    localparam int LEVELS         = 4;
    localparam int MISS_FRAMES    = 60;
    localparam int LEVELUP_FRAMES = 120;
    localparam int OVER_FRAMES    = 180;
    localparam int SERVE_FRAMES   = 300;

    logic       pclk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       mouse_left;
    logic       ball_lost;
    logic       bricks_clear;
    logic       paddle_en;
    logic       ball_hold;
    logic       ball_launch;
    logic       field_reload;
    logic [1:0] lives;
    logic [1:0] level;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: game phase plus frames remaining in the current pause
    int m_state, m_lives, m_level, m_remain;
    bit m_prev, m_launch, m_reload;

    round_ctl dut (
        .pclk         (pclk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .mouse_left   (mouse_left),
        .ball_lost    (ball_lost),
        .bricks_clear (bricks_clear),
        .paddle_en    (paddle_en),
        .ball_hold    (ball_hold),
        .ball_launch  (ball_launch),
        .field_reload (field_reload),
        .lives        (lives),
        .level        (level),
        .state        (state)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pause_len(input int s);
        case (s)
            1: return SERVE_FRAMES;
            3: return MISS_FRAMES;
            4: return LEVELUP_FRAMES;
            5: return OVER_FRAMES;
            default: return 0;
        endcase
    endfunction

    task automatic m_enter(input int s);
        m_state  = s;
        m_remain = pause_len(s);
    endtask

    task automatic m_reset();
        m_state = 0; m_lives = LIVES_INIT; m_level = 0; m_remain = 0;
        m_prev = 0; m_launch = 0; m_reload = 0;
    endtask

    task automatic model_step(input bit ml, input bit bl, input bit bc, input bit ft);
        bit click;
        bit auto_fire;
        click = ml && !m_prev;
        auto_fire = 0;
        m_prev = ml;
        m_launch = 0;
        m_reload = 0;
        case (m_state)
            0: if (click) begin
                m_lives = LIVES_INIT; m_level = 0; m_reload = 1; m_enter(1);
            end
            1: begin
`ifdef ROUND_CTL_AUTO_SERVE_EN
                if (ft) m_remain = m_remain - 1;
                auto_fire = (m_remain == 0);
`endif
                if (click || auto_fire) begin
                    m_launch = 1; m_enter(2);
                end
            end
            2: begin
                if (bc) m_enter(4);
                else if (bl) begin
                    if (m_lives > 1) begin m_lives = m_lives - 1; m_enter(3); end
                    else begin m_lives = 0; m_enter(5); end
                end
            end
            default: if (ft) begin
                m_remain = m_remain - 1;
                if (m_remain == 0) begin
                    if (m_state == 3) m_enter(1);
                    else if (m_state == 4) begin
                        m_level = (m_level + 1) % LEVELS; m_reload = 1; m_enter(1);
                    end else m_enter(0);
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("state", state, m_state);
        chk("lives", lives, m_lives);
        chk("level", level, m_level);
        chk("paddle_en", paddle_en, (m_state == 1 || m_state == 2));
        chk("ball_hold", ball_hold, (m_state != 2));
        chk("ball_launch", ball_launch, m_launch);
        chk("field_reload", field_reload, m_reload);
    endtask

    task automatic step(input bit ml, input bit bl, input bit bc, input bit ft);
        @(negedge pclk);
        mouse_left = ml; ball_lost = bl; bricks_clear = bc; frame_tick = ft;
        @(posedge pclk);
        model_step(ml, bl, bc, ft);
        #1;
        compare_all();
    endtask

    // n frame ticks, each preceded by a quiet cycle; ends on the tick edge
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0);
            step(0, 0, 0, 1);
        end
    endtask

    task automatic serve_and_play();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        int launches;
        bit ml;
        reset = 1; mouse_left = 0; ball_lost = 0; bricks_clear = 0; frame_tick = 0;
        m_reset();
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_lives", lives, LIVES_INIT);
        chk("rst_level", level, 0);
        chk("rst_hold", ball_hold, 1);
        chk("rst_paddle", paddle_en, 0);
        chk("rst_launch", ball_launch, 0);
        chk("rst_reload", field_reload, 0);
        @(negedge pclk);
        reset = 0;

        // start game, then launch
        step(1, 0, 0, 0);
        chk("t2_reload", field_reload, 1);
        chk("t2_state_serve", state, 1);
        step(0, 0, 0, 0);
        chk("t2_reload_off", field_reload, 0);
        step(1, 0, 0, 0);
        chk("t2_launch", ball_launch, 1);
        chk("t2_state_play", state, 2);
        chk("t2_hold", ball_hold, 0);
        step(0, 0, 0, 0);
        chk("t2_launch_off", ball_launch, 0);

        // reach level 1, lives 2, then reset mid-PLAY
        step(0, 0, 1, 0);
        run_ticks(LEVELUP_FRAMES);
        chk("lv1_level", level, 1);
        serve_and_play();
        step(0, 1, 0, 0);
        chk("miss_lives", lives, 2);
        chk("miss_state", state, 3);
        run_ticks(MISS_FRAMES - 1);
        chk("miss_hold_state", state, 3);
        run_ticks(1);
        chk("miss_exit_state", state, 1);
        chk("miss_no_reload", field_reload, 0);
        serve_and_play();
        chk("pre_rst_state", state, 2);
        #2 reset = 1;
        #1;
        chk("t1_state", state, 0);
        chk("t1_lives", lives, LIVES_INIT);
        chk("t1_level", level, 0);
        chk("t1_hold", ball_hold, 1);
        chk("t1_paddle", paddle_en, 0);
        m_reset();
        reset = 0;

        // lose all lives
        serve_and_play();
        serve_and_play();
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 0);
            chk("t3_lives", lives, 2 - k);
            chk("t3_state_miss", state, 3);
            run_ticks(MISS_FRAMES);
            chk("t3_state_serve", state, 1);
            serve_and_play();
        end
        step(0, 1, 0, 0);
        chk("t3_lives_zero", lives, 0);
        chk("t3_state_over", state, 5);
        run_ticks(OVER_FRAMES - 1);
        chk("t3_still_over", state, 5);
        run_ticks(1);
        chk("t3_state_idle", state, 0);
        chk("t3_lives_stay", lives, 0);

        // climb to level 3 and wrap
        serve_and_play();
        serve_and_play();
        repeat (3) begin
            step(0, 0, 1, 0);
            run_ticks(LEVELUP_FRAMES);
            serve_and_play();
        end
        chk("t4_level3", level, 3);
        step(0, 0, 1, 0);
        chk("t4_state_lvup", state, 4);
        run_ticks(LEVELUP_FRAMES);
        chk("t4_level_wrap", level, 0);
        chk("t4_reload", field_reload, 1);
        chk("t4_state_serve", state, 1);
        step(0, 0, 0, 0);
        chk("t4_reload_off", field_reload, 0);

        // down to one life, then clear and lose together
        serve_and_play();
        repeat (2) begin
            step(0, 1, 0, 0);
            run_ticks(MISS_FRAMES);
            serve_and_play();
        end
        chk("t5_lives_one", lives, 1);
        step(0, 1, 1, 0);
        chk("t5_state_lvup", state, 4);
        chk("t5_lives_kept", lives, 1);
        step(1, 1, 0, 0);
        step(0, 1, 1, 1);
        chk("t5_ignore_state", state, 4);
        chk("t5_ignore_lives", lives, 1);
        run_ticks(LEVELUP_FRAMES - 1);
        chk("t5_serve", state, 1);
        chk("t5_level", level, 1);

        // SERVE without clicks
        launches = 0;
`ifdef ROUND_CTL_AUTO_SERVE_EN
        run_ticks(SERVE_FRAMES - 1);
        chk("t6_waiting", state, 1);
        run_ticks(1);
        chk("t6_auto_launch", ball_launch, 1);
        chk("t6_auto_play", state, 2);
`else
        for (int i = 0; i < 1000; i++) begin
            step(0, 0, 0, 0);
            launches += int'(ball_launch);
            step(0, 0, 0, 1);
            launches += int'(ball_launch);
        end
        chk("t6_no_launch", launches, 0);
        chk("t6_still_serve", state, 1);
`endif

        // randomized play
        ml = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) ml = ~ml;
            step(ml, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_ctl.md
Name: round_ctl

Overview:
- Game-round sequencer for the Arkanoid top level.
- Gates the paddle controller, holds or launches the ball, tracks lives and level, and schedules the timed pauses between rounds.
- Sits between mouse/ball/brick logic and the drawing chain.
- All timing is counted in display frames via a one-cycle frame_tick pulse.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- LEVELS, 4, number of levels; level index wraps after LEVELS-1 (1..4).
- MISS_FRAMES, 60, frames of pause after a lost ball.
- LEVELUP_FRAMES, 120, frames of pause after a cleared field.
- OVER_FRAMES, 180, frames of the game-over screen before returning to IDLE.
- SERVE_FRAMES, 300, auto-serve timeout; used only with AUTO_SERVE_EN.

Ports:
- pclk  in  1  pixel clock, the single clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-pclk pulse per frame (start of vblank).
- mouse_left  in  1  left button level, already synchronous to pclk.
- ball_lost  in  1  one-cycle pulse: ball passed below the paddle.
- bricks_clear  in  1  one-cycle pulse: last brick destroyed.
- paddle_en  out  1  1 = paddle follows the mouse; 0 = paddle frozen.
- ball_hold  out  1  1 = ball is glued to the paddle centre.
- ball_launch  out  1  one-cycle pulse: release the ball.
- field_reload  out  1  one-cycle pulse: rebuild the brick map for the current level.
- lives  out  2  remaining lives.
- level  out  2  current level index.
- state  out  3  FSM state code, for the HUD.

Behaviour:
- Clock and reset: one clock, pclk; reset is asynchronous and active-high.
- Reset values: state=IDLE, paddle_en=0, ball_hold=1, ball_launch=0, field_reload=0, lives=LIVES_INIT, level=0, frame counter=0, click register=0.
- All outputs are registered.
- Click detection: click = mouse_left & ~mouse_left_q, where mouse_left_q is registered. A click is acted on in the cycle it is detected; outputs change on the next edge.
- State encoding (package constants): IDLE=0, SERVE=1, PLAY=2, MISS=3, LEVELUP=4, OVER=5. Codes 6–7 are illegal and recover to IDLE on the next cycle.
- IDLE: paddle_en=0, ball_hold=1.
  - On click: lives<=LIVES_INIT, level<=0, pulse field_reload, go to SERVE.
- SERVE: paddle_en=1, ball_hold=1.
  - On click: pulse ball_launch, ball_hold<=0, go to PLAY.
- PLAY: paddle_en=1, ball_hold=0. Clicks are ignored.
  - bricks_clear: go to LEVELUP.
  - ball_lost when lives>1: lives<=lives-1, go to MISS.
  - ball_lost when lives==1: lives<=0, go to OVER.
  - bricks_clear and ball_lost in the same cycle: bricks_clear wins; lives unchanged.
- MISS: paddle_en=0, ball_hold=1. Frame counter cleared on entry, incremented on each frame_tick.
  - When counter==MISS_FRAMES-1 and frame_tick: go to SERVE (no field_reload).
- LEVELUP: same counting with LEVELUP_FRAMES.
  - On exit: level<=(level==LEVELS-1)?0:level+1, pulse field_reload in the same cycle as the level update, go to SERVE.
- OVER: paddle_en=0, ball_hold=1.
  - After OVER_FRAMES ticks: go to IDLE.
  - lives stays 0 until the next game start.
- Pulse inputs outside PLAY are ignored. A click outside IDLE/SERVE is ignored.
- frame_tick and a state exit together: the tick counts toward the exit, and the counter resets to 0 on the transition.
- The frame counter is 8 bits wide and saturates; parameters above 255 are illegal.
- Reset mid-round: immediate return to reset values; any pulse output in flight is dropped.

Optional Feature:
- Macro: ROUND_CTL_AUTO_SERVE_EN.
- With it defined: SERVE also counts frame_ticks. After SERVE_FRAMES ticks without a click, it auto-launches exactly as a click would. A click resets nothing and launches immediately. The counter clears on SERVE entry. The counter widens to 9 bits.
- Without it: SERVE waits indefinitely for a click; no extra counter logic.

Decomposition:
- Shared package game_pkg holds:
  - state code constants ST_IDLE..ST_OVER and STATE_W=3;
  - LIVES_W=2, LEVEL_W=2;
  - the default frame counts.
- One sub-module, frame_timer:
  - inputs: pclk, reset, clear, frame_tick, limit;
  - output: done, a combinational pulse when frame_tick arrives with count==limit-1.
  - It is instantiated once and shared by MISS/LEVELUP/OVER (and SERVE under the macro), with the limit muxed by state.

Test Plan:
1. Reset asserted mid-PLAY with lives=2, level=1 -> asynchronously state=0, lives=3, level=0, ball_hold=1, paddle_en=0.
2. Click in IDLE, then click in SERVE -> field_reload pulse 1 cycle after the first click; state SERVE; after the second click, ball_launch is high for exactly 1 cycle and state=2, ball_hold=0.
3. In PLAY with lives=3, pulse ball_lost -> lives=2, state=3; after exactly 60 frame_ticks state=1. Repeat twice more -> on the third loss lives=0, state=5; after 180 ticks state=0.
4. level=3, pulse bricks_clear -> state=4; after 120 ticks level=0 (wrap), field_reload pulse, state=1.
5. bricks_clear and ball_lost in the same cycle in PLAY with lives=1 -> state=4, lives=1. Clicks and ball_lost during MISS/LEVELUP have no effect.
6. With ROUND_CTL_AUTO_SERVE_EN, SERVE with no click for 300 ticks -> ball_launch pulse, state=2. Without the macro, the bench sees no launch after 1000 ticks.
